// File: rtl/full_adder_rca.sv
// Parameterised ripple-carry adder built from chained full-adder cells, with an
// optional one-cycle registered copy of sum, carry-out and signed overflow.
module full_adder_rca #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cy_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] y_o,
  output logic             cy_o,
  output logic [WIDTH-1:0] y_r_o,
  output logic             cy_r_o,
  output logic             ov_r_o,
  output logic             vld_o
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  logic             ov;

  assign c[0] = cy_i;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign s[i]   = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1] = (a_i[i] & b_i[i]) | (a_i[i] & c[i]) | (b_i[i] & c[i]);
  end

  assign y_o  = s;
  assign cy_o = c[WIDTH];
  // Carry into vs. out of the MSB cell; for WIDTH=1 this is c[1]^c[0].
  assign ov   = c[WIDTH] ^ c[WIDTH-1];

  logic [WIDTH-1:0] y_q,   y_d;
  logic             cy_q,  cy_d;
  logic             ov_q,  ov_d;
  logic             vld_q, vld_d;

  always_comb begin
    y_d   = y_q;
    cy_d  = cy_q;
    ov_d  = ov_q;
    vld_d = en_i;
    if (en_i) begin
      y_d  = s;
      cy_d = c[WIDTH];
      ov_d = ov;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      y_q   <= '0;
      cy_q  <= 1'b0;
      ov_q  <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      cy_q  <= cy_d;
      ov_q  <= ov_d;
      vld_q <= vld_d;
    end
  end

  assign y_r_o  = y_q;
  assign cy_r_o = cy_q;
  assign ov_r_o = ov_q;
  assign vld_o  = vld_q;

endmodule

// File: tb/tb_full_adder_rca.sv
// Scoreboard bench for full_adder_rca: stimulus pushes expected registered
// results, an independent monitor pops and compares on every vld_o.
module tb_full_adder_rca;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] a, b;
  logic             cy, en;
  logic [WIDTH-1:0] y, y_r;
  logic             cy_o, cy_r, ov_r, vld;

  full_adder_rca #(.WIDTH(WIDTH)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .a_i    (a),
    .b_i    (b),
    .cy_i   (cy),
    .en_i   (en),
    .y_o    (y),
    .cy_o   (cy_o),
    .y_r_o  (y_r),
    .cy_r_o (cy_r),
    .ov_r_o (ov_r),
    .vld_o  (vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned passed = 0;
  int unsigned total  = 0;

  // {cy, ov, y}
  logic [WIDTH+1:0] sb_q[$];
  logic [WIDTH+1:0] last_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic [7:0] a, b;
    logic       cy;
    logic [7:0] y;
    logic       co, ov;
  } vec_t;

  vec_t vecs[9] = '{
    '{8'd0,   8'd0,   1'b0, 8'd0,   1'b0, 1'b0},
    '{8'd1,   8'd1,   1'b1, 8'd3,   1'b0, 1'b0},
    '{8'd255, 8'd255, 1'b1, 8'd255, 1'b1, 1'b0},
    '{8'd255, 8'd0,   1'b1, 8'd0,   1'b1, 1'b0},
    '{8'd0,   8'd255, 1'b0, 8'd255, 1'b0, 1'b0},
    '{8'd100, 8'd155, 1'b1, 8'd0,   1'b1, 1'b0},
    '{8'd127, 8'd1,   1'b0, 8'd128, 1'b0, 1'b1},
    '{8'd128, 8'd128, 1'b0, 8'd0,   1'b1, 1'b1},
    '{8'd200, 8'd100, 1'b0, 8'd44,  1'b1, 1'b0}
  };

  task automatic apply_vec(input vec_t v, input logic enable);
    @(negedge clk);
    a = v.a; b = v.b; cy = v.cy; en = enable;
    #1;
    chk("comb_y",  32'(y),    32'(v.y));
    chk("comb_cy", 32'(cy_o), 32'(v.co));
    if (enable && rst_n) begin
      last_exp = {v.co, v.ov, v.y};
      sb_q.push_back(last_exp);
    end
  endtask

  // Monitor: compares every valid registered result against the scoreboard.
  initial begin
    logic [WIDTH+1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (vld) begin
        if (sb_q.size() == 0) begin
          chk("spurious_vld", 32'(vld), 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("reg_y",  32'(y_r),  32'(e[WIDTH-1:0]));
          chk("reg_cy", 32'(cy_r), 32'(e[WIDTH+1]));
          chk("reg_ov", 32'(ov_r), 32'(e[WIDTH]));
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [8:0] ref_sum;
    rst_n = 1'b0; en = 1'b0; a = 8'd0; b = 8'd0; cy = 1'b0;
    #2;
    chk("rst_y_r",   32'(y_r),  32'd0);
    chk("rst_cy_r",  32'(cy_r), 32'd0);
    chk("rst_ov_r",  32'(ov_r), 32'd0);
    chk("rst_vld",   32'(vld),  32'd0);
    a = 8'd20; b = 8'd22; cy = 1'b1;
    #1;
    chk("rst_comb_y", 32'(y), 32'd43);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) apply_vec(vecs[i], 1'b1);

    // Three idle cycles: data holds, vld low.
    v = vecs[1];
    for (int i = 0; i < 3; i++) begin
      apply_vec(v, 1'b0);
      @(posedge clk);
      #1;
      chk("hold_vld", 32'(vld),  32'd0);
      chk("hold_y",   32'(y_r),  32'(last_exp[WIDTH-1:0]));
      chk("hold_cy",  32'(cy_r), 32'(last_exp[WIDTH+1]));
      chk("hold_ov",  32'(ov_r), 32'(last_exp[WIDTH]));
    end

    // Capture a result, then reset between edges.
    apply_vec(vecs[6], 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_y_r",  32'(y_r),  32'd0);
    chk("midrst_cy_r", 32'(cy_r), 32'd0);
    chk("midrst_ov_r", 32'(ov_r), 32'd0);
    chk("midrst_vld",  32'(vld),  32'd0);
    a = 8'd37; b = 8'd5; cy = 1'b0; en = 1'b1;
    #1;
    chk("midrst_comb_y", 32'(y), 32'd42);
    @(posedge clk);
    #1;
    chk("rst_wins_vld", 32'(vld), 32'd0);
    chk("rst_wins_y_r", 32'(y_r), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; en = 1'b0;

    // First enabled edge after release captures normally.
    apply_vec(vecs[7], 1'b1);
    apply_vec(vecs[2], 1'b0);
    @(posedge clk);
    #1;
    chk("post_idle_vld", 32'(vld), 32'd0);

    // Exhaustive combinational sweep against a + b + cy.
    for (int ia = 0; ia < 256; ia++) begin
      for (int ib = 0; ib < 256; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          a = 8'(ia); b = 8'(ib); cy = 1'(ic);
          #1;
          ref_sum = 9'(ia + ib + ic);
          total++;
          if ({cy_o, y} === ref_sum) passed++;
          else $display("FAIL sweep a=%0d b=%0d cy=%0d: got %0d expected %0d",
                        ia, ib, ic, {cy_o, y}, ref_sum);
        end
      end
    end

    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
